retinex_gain_lut: RTL

Parametrised successor to the fixed retinex enhancer. It computes the per-pixel brightness V as the maximum over CH channels, looks up a gain for V in a programmable, double-buffered table, and multiplies every channel by that gain with saturation. The host loads curves such as gamma, reciprocal or clamped variants into the table at run time. The block sits between video input and output in the pixel stream and adds frame-synchronous table swap, bypass mode and line tracking.

---
 rtl/retinex_gain_lut.sv | 134 +++++++++++++
 1 files changed

// File: rtl/retinex_gain_lut.sv
// retinex_gain_lut: scales every channel by a gain looked up from the pixel's max channel
// in a double-buffered, host-programmable table with frame-synchronous swap and bypass.
module retinex_gain_lut #(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int GAIN_IW = 8,
  parameter int GAIN_FW = 8,
  parameter int WIDTH = 1920
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       src_ready,
  input  logic                       src_valid,
  input  logic                       src_sof,
  input  logic [CH*DW-1:0]           src_data,
  output logic                       dst_valid,
  output logic                       dst_sof,
  output logic                       dst_eol,
  output logic [CH*DW-1:0]           dst_data,
  input  logic                       lut_we,
  input  logic [DW-1:0]              lut_addr,
  input  logic [GAIN_IW+GAIN_FW-1:0] lut_wdata,
  input  logic                       lut_swap,
  output logic                       lut_bank,
  input  logic                       cfg_bypass
);
  localparam int GW = GAIN_IW + GAIN_FW;
  localparam int PW = DW + GW;
  localparam int SW = DW + GAIN_IW;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [GW-1:0] UNITY = GW'(1) << GAIN_FW;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [DW-1:0] init_addr;
  logic swap_pending, bypass_frame;
  logic [CW-1:0] col;
  logic [GW-1:0] bank0 [2**DW];
  logic [GW-1:0] bank1 [2**DW];

  logic accept, swap_now, byp_now, eol_now, run_we, wr0, wr1;
  logic [CW-1:0] col_now;
  logic [DW-1:0] v_now, waddr;
  logic [GW-1:0] wdat;

  logic s1_vld, s1_sof, s1_eol, s1_bank, s1_byp;
  logic [DW-1:0] s1_v;
  logic [CH*DW-1:0] s1_data, s2_data;
  logic s2_vld, s2_sof, s2_eol;
  logic [GW-1:0] s2_gain;
  logic s3_vld, s3_sof, s3_eol;
  logic [SW-1:0] s3_q [CH];
  logic [CH*DW-1:0] sat_data;

  always_comb begin
    accept = src_valid & src_ready;
    swap_now = accept & src_sof & (swap_pending | lut_swap);
    byp_now = accept & src_sof ? cfg_bypass : bypass_frame;
    col_now = src_sof ? '0 : col;
    eol_now = col_now == LAST;
    run_we = state == RUN & lut_we;
    waddr = state == INIT ? init_addr : lut_addr;
    wdat = state == INIT ? UNITY : lut_wdata;
    // INIT fills both banks; run-time writes only ever land in the inactive bank
    wr0 = ~rst & (state == INIT | run_we & lut_bank);
    wr1 = ~rst & (state == INIT | run_we & ~lut_bank);
    v_now = '0;
    for (int k = 0; k < CH; k++)
      v_now = src_data[DW*k +: DW] > v_now ? src_data[DW*k +: DW] : v_now;
    sat_data = '0;
    for (int k = 0; k < CH; k++)
      sat_data[DW*k +: DW] = |s3_q[k][SW-1:DW] ? {DW{1'b1}} : s3_q[k][DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      init_addr <= '0;
      src_ready <= 1'b0;
      lut_bank <= 1'b0;
      swap_pending <= 1'b0;
      bypass_frame <= 1'b0;
      col <= '0;
    end else begin
      if (state == INIT) begin
        init_addr <= init_addr + 1'b1;
        if (&init_addr) begin
          state <= RUN;
          src_ready <= 1'b1;
        end
      end
      if (swap_now) lut_bank <= ~lut_bank;
      swap_pending <= swap_now ? 1'b0 : swap_pending | (state == RUN & lut_swap);
      if (accept & src_sof) bypass_frame <= cfg_bypass;
      if (accept) col <= eol_now ? '0 : col_now + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0) bank0[waddr] <= wdat;
    if (wr1) bank1[waddr] <= wdat;
  end

  // bank and bypass travel with each pixel so frames already in flight keep their table
  always_ff @(posedge clk) begin
    s1_data <= src_data;
    s1_v <= v_now;
    s1_bank <= lut_bank ^ swap_now;
    s1_byp <= byp_now;
    s2_data <= s1_data;
    s2_gain <= s1_byp ? UNITY : s1_bank ? bank1[s1_v] : bank0[s1_v];
    for (int k = 0; k < CH; k++)
      s3_q[k] <= SW'((PW'(s2_data[DW*k +: DW]) * PW'(s2_gain)) >> GAIN_FW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_vld, s1_sof, s1_eol} <= '0;
      {s2_vld, s2_sof, s2_eol} <= '0;
      {s3_vld, s3_sof, s3_eol} <= '0;
      {dst_valid, dst_sof, dst_eol} <= '0;
      dst_data <= '0;
    end else begin
      s1_vld <= accept;
      s1_sof <= accept & src_sof;
      s1_eol <= accept & eol_now;
      {s2_vld, s2_sof, s2_eol} <= {s1_vld, s1_sof, s1_eol};
      {s3_vld, s3_sof, s3_eol} <= {s2_vld, s2_sof, s2_eol};
      {dst_valid, dst_sof, dst_eol} <= {s3_vld, s3_sof, s3_eol};
      if (s3_vld) dst_data <= sat_data;
    end
  end
endmodule
